// File: rtl/time_of_day_counter.sv
// rtl/time_of_day_counter.sv - BCD HH:MM:SS time-of-day counter with validated MSF load
// Optional sync-loss timeout enabled by defining SYNC_TIMEOUT_EN.
module time_of_day_counter #(
    parameter logic [9:0] SYNC_TIMEOUT_MIN = 10'd60
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       second_inc_i,
    input  logic       load_i,
    input  logic [7:0] load_hours_i,
    input  logic [7:0] load_minutes_i,
    output logic [7:0] hours_o,
    output logic [7:0] minutes_o,
    output logic [7:0] seconds_o,
    output logic       minute_tick_o,
    output logic       time_valid_o,
    output logic       load_err_o
);

    logic [7:0] r_hours;
    logic [7:0] r_minutes;
    logic [7:0] r_seconds;
    logic       r_minute_tick;
    logic       r_time_valid;
    logic       r_load_err;

    logic       w_load_ok;
    logic       w_sec_wrap;
    logic       w_min_wrap;

    // Units digits must be decimal; the full-byte hours compare covers both tens and 20-23 limits.
    assign w_load_ok  = (load_hours_i[3:0] <= 4'd9) &&
                        (load_minutes_i[3:0] <= 4'd9) &&
                        (load_minutes_i[7:4] <= 4'd5) &&
                        (load_hours_i <= 8'h23);
    assign w_sec_wrap = (r_seconds == 8'h59);
    assign w_min_wrap = (r_minutes == 8'h59);

    function automatic logic [7:0] bcd_inc(input logic [7:0] v);
        if (v[3:0] == 4'd9) begin
            bcd_inc = {v[7:4] + 4'd1, 4'h0};
        end else begin
            bcd_inc = v + 8'd1;
        end
    endfunction

`ifdef SYNC_TIMEOUT_EN
    logic [9:0] r_timeout_cnt;
`else
    logic w_unused_timeout_min;
    assign w_unused_timeout_min = ^SYNC_TIMEOUT_MIN;
`endif

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_hours       <= 8'h00;
            r_minutes     <= 8'h00;
            r_seconds     <= 8'h00;
            r_minute_tick <= 1'b0;
            r_time_valid  <= 1'b0;
            r_load_err    <= 1'b0;
`ifdef SYNC_TIMEOUT_EN
            r_timeout_cnt <= 10'd0;
`endif
        end else begin
            r_minute_tick <= 1'b0;
            r_load_err    <= 1'b0;
            if (load_i && w_load_ok) begin
                // An accepted load is a minute marker, so it swallows any coincident second tick.
                r_hours       <= load_hours_i;
                r_minutes     <= load_minutes_i;
                r_seconds     <= 8'h00;
                r_time_valid  <= 1'b1;
                r_minute_tick <= 1'b1;
`ifdef SYNC_TIMEOUT_EN
                r_timeout_cnt <= 10'd0;
`endif
            end else begin
                r_load_err <= load_i;
                if (second_inc_i) begin
                    if (w_sec_wrap) begin
                        r_seconds     <= 8'h00;
                        r_minute_tick <= 1'b1;
                        if (w_min_wrap) begin
                            r_minutes <= 8'h00;
                            r_hours   <= (r_hours == 8'h23) ? 8'h00 : bcd_inc(r_hours);
                        end else begin
                            r_minutes <= bcd_inc(r_minutes);
                        end
`ifdef SYNC_TIMEOUT_EN
                        if (r_timeout_cnt < SYNC_TIMEOUT_MIN) begin
                            r_timeout_cnt <= r_timeout_cnt + 10'd1;
                            if (r_timeout_cnt + 10'd1 == SYNC_TIMEOUT_MIN) begin
                                r_time_valid <= 1'b0;
                            end
                        end
`endif
                    end else begin
                        r_seconds <= bcd_inc(r_seconds);
                    end
                end
            end
        end
    end

    assign hours_o       = r_hours;
    assign minutes_o     = r_minutes;
    assign seconds_o     = r_seconds;
    assign minute_tick_o = r_minute_tick;
    assign time_valid_o  = r_time_valid;
    assign load_err_o    = r_load_err;

endmodule

// File: doc/time_of_day_counter.md
Name: time_of_day_counter

Overview:
- Consumes the one-cycle 1 Hz tick from the second counter.
- Keeps the displayed time of day (HH:MM:SS) as BCD digits.
- Accepts a load of hours/minutes from the MSF frame decoder at each minute marker.
- Drives the display mux, plus a validity flag and a minute tick for downstream logic.

Parameters:
- SYNC_TIMEOUT_MIN, 10'd60, minutes without a successful load before time_valid_o drops (used only with SYNC_TIMEOUT_EN).

Ports:
- clk_i  input  1  system clock (1 kHz domain)
- rst_i  input  1  asynchronous active-high reset
- second_inc_i  input  1  one-cycle pulse, advance time by 1 s
- load_i  input  1  one-cycle pulse, load decoded time
- load_hours_i  input  8  BCD hours {tens[7:4], units[3:0]}
- load_minutes_i  input  8  BCD minutes {tens[7:4], units[3:0]}
- hours_o  output  8  BCD hours
- minutes_o  output  8  BCD minutes
- seconds_o  output  8  BCD seconds
- minute_tick_o  output  1  one-cycle pulse on every minute boundary
- time_valid_o  output  1  time has been loaded from MSF and is trusted
- load_err_o  output  1  one-cycle pulse, rejected load

Behaviour:
- Reset (asynchronous, rst_i high): all outputs 0 (00:00:00), time_valid_o=0, pulses 0, timeout counter 0. Outputs hold 0 while rst_i is asserted.
- All outputs are registered. Updates are visible the cycle after the qualifying input edge.
- Increment (second_inc_i=1, load_i=0):
  - seconds units 0-9; at 9 wrap to 0 and carry to seconds tens 0-5.
  - 59 -> 00 carries to minutes; minutes 59 -> 00 carries to hours.
  - hours 23 -> 00, with wrap checked on the full BCD value 8'h23.
  - minute_tick_o=1 for exactly one cycle whenever seconds go 59 -> 00 via increment.
- Load validation (load_i=1):
  - Accept if every units digit <=9, minute tens <=5, and hours <=8'h23 (hours tens <=2; if tens==2 then units <=3).
  - Accepted: hours_o/minutes_o take the inputs, seconds_o=8'h00, time_valid_o=1, timeout counter cleared.
  - Accepted load also produces minute_tick_o=1 for one cycle, because the load marks a minute boundary.
  - Rejected: time registers unchanged, load_err_o=1 for one cycle, time_valid_o unchanged.
- Simultaneous load_i and second_inc_i in the same cycle:
  - Accepted load wins; the second_inc is discarded.
  - Rejected load still performs the increment and pulses load_err_o.
- No other state machine. The counters are a BCD digit chain plus a valid/timeout register.
- second_inc_i is never held high for more than one cycle. If it is, each high cycle increments once.
- Registers for load data must not latch input values when load_i=0.

Optional Feature:
- Macro: SYNC_TIMEOUT_EN.
- With the macro:
  - A 10-bit minute counter increments on each minute_tick_o caused by increment (not by load).
  - The counter saturates at SYNC_TIMEOUT_MIN.
  - When it reaches SYNC_TIMEOUT_MIN, time_valid_o clears on the same cycle the count is reached. The time keeps running.
  - An accepted load clears the counter and sets time_valid_o.
- Without the macro: no timeout counter. time_valid_o stays 1 from the first accepted load until reset.

Test Plan:
- Reset mid-count: assert rst_i asynchronously at 12:34:56 -> outputs 00:00:00, time_valid_o=0 immediately, without waiting for a clock edge.
- Rollover: load 23:59 then 59 second_inc_i pulses -> 23:59:59; one more -> 00:00:00, with minute_tick_o high exactly one cycle.
- BCD carry: from 00:09:59 one second_inc_i -> 00:10:00; from 09:59:59 -> 10:00:00.
- Load validation:
  - load 8'h24/8'h00 -> load_err_o pulse, time unchanged, time_valid_o stays 0.
  - load 8'h12/8'h5A -> rejected.
  - load 8'h12/8'h34 -> 12:34:00, time_valid_o=1.
- Collision: at 07:15:30 assert load_i (8'h08/8'h00) and second_inc_i same cycle -> 08:00:00, not 08:00:01.
- Timeout (SYNC_TIMEOUT_EN, SYNC_TIMEOUT_MIN=2): load 10:00, run 120 s -> time_valid_o drops at 10:02:00, time still advances. Reload 10:05 -> time_valid_o=1. Without the macro, time_valid_o remains 1.
